nco_1mhz: RTL and testbench
===========================

# nco_1mhz

Numerically controlled oscillator producing a 13-bit two's-complement sine sample stream from a 32-bit phase accumulator. It sits at the signal-generation front of the ADC test chain and supplies a reference tone. Output frequency is f_clk·phi_inc_i/2^32. For example, 100 MHz clk with phi_inc_i = 0x00418937 gives ≈100 kHz, i.e. 1000 samples per period.

## Interface
- ACC_W, 32: phase accumulator and increment width.
- PHASE_W, 12: truncated phase bits used for lookup (acc[31:20]).
- OUT_W, 13: output sample width (signed).
- AMP, 4095: peak amplitude (2^(OUT_W-1) - 1).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clken  in  1  clock enable; low freezes every register, including out_valid.
- phi_inc_i  in  32  phase increment, unsigned, sampled every enabled cycle.
- fsin_o  out  13  sine sample, two's complement, range -4095..+4095.
- out_valid  out  1  high once the pipeline holds real samples.

## Operation
- Accumulator: on reset, acc = 0. Each enabled cycle, acc <= acc + phi_inc_i, modulo 2^32, carry discarded.
- Phase p = acc[31:20], no dithering or rounding.
- Quadrant q = p[11:10], offset a = p[9:0].
- Quarter-wave ROM of 1025 entries, 12 bits unsigned: ROM[i] = round(4095·sin(π/2·i/1024)), i = 0..1024. So ROM[0] = 0 and ROM[1024] = 4095.
- Per quadrant:
  - q=0: +ROM[a]
  - q=1: +ROM[1024-a]
  - q=2: -ROM[a]
  - q=3: -ROM[1024-a]
- Negation is exact two's complement on 13 bits. -4095 = 13'h1001. Code -4096 is never produced.
- Sample k after reset (k = 0, 1, …) equals the quadrant formula at phase (k·phi_inc_i mod 2^32)>>20, when phi_inc_i is held constant.
- A change of phi_inc_i takes effect on the next enabled accumulation. It causes no phase reset and no glitch beyond the new increment.

## Timing
- Reset, while reset_n = 0 at a rising edge: acc, every pipeline register and fsin_o are 0; out_valid is 0. Reset has priority over clken.
- Pipeline, each stage advancing only when clken = 1:
  - S1: phase register captures acc[31:20].
  - S2: ROM data register, plus delayed sign bit.
  - S3: fsin_o register applies the sign.
- Latency from the accumulator value to fsin_o is 3 enabled edges.
- out_valid is driven by a 3-deep valid shift register filled with 1s after reset. It rises on the 3rd enabled edge after reset_n returns high. On that same edge fsin_o = 0, which is sample 0. out_valid then stays high until the next reset.
- clken = 0: all state holds, including fsin_o and out_valid. Operation resumes seamlessly with no lost or duplicated samples.
- Reset mid-operation: the next enabled edge after release restarts the sequence from phase 0, with the identical 3-edge valid delay.
- Wrap-around: acc overflow simply wraps; the phase remains continuous.

## Structure
- Shared package nco_pkg holds:
  - ACC_W, PHASE_W, OUT_W and AMP;
  - the quarter-ROM depth constant (1025).
- One sub-module, nco_sin_rom: 1025×12 synchronous ROM (one registered read port). Contents come from a generated init file nco_sin_rom.hex, or a constant function computing round(4095·sin(·)).
- Top level contains the accumulator, quadrant logic, sign pipeline and valid shift register.

## Test plan
- phi_inc_i = 0x40000000: after valid, fsin_o repeats 0, 4095, 0, -4095; out_valid rises exactly 3 edges after reset release.
- phi_inc_i = 0x20000000: sequence 0, 2896, 4095, 2896, 0, -2896, -4095, -2896, repeating.
- phi_inc_i = 0x00418937, 100 MHz clk: first samples 0, 25, …; period 1000 samples; min -4095, max ≤ 4095; output matches the golden rounded-sine model bit-exactly.
- phi_inc_i = 0: fsin_o constant 0 with out_valid high.
- clken toggled pseudo-randomly with phi_inc_i = 0x20000000: the enabled-cycle output sequence is identical to the clken = 1 run, and outputs hold during clken = 0.
- Reset asserted mid-stream: at the next edge fsin_o = 0 and out_valid = 0; after release the sequence restarts from 0 with 3-edge latency. Also change phi_inc_i mid-run and check phase continuity.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared widths and constants for the NCO, plus the elaboration-time
// quarter-sine generator that fills the lookup ROM.
package nco_pkg;

    localparam int ACC_W     = 32;
    localparam int PHASE_W   = 12;
    localparam int OUT_W     = 13;
    localparam int AMP       = 4095;
    localparam int ROM_DEPTH = 1025;
    localparam int ROM_W     = 12;
    localparam int ROM_AW    = 11;
    localparam int OFS_W     = PHASE_W - 2;
    localparam int FRAC      = 60;

    // atan(1/m) in 2^-FRAC fixed point, used to build pi with Machin's formula
    function automatic logic [127:0] atanInv(input int unsigned m);
        logic [127:0] power;
        logic [127:0] sum;
        logic [127:0] mm;
        mm    = 128'(m) * 128'(m);
        power = (128'd1 << FRAC) / 128'(m);
        sum   = power;
        for (int k = 1; k < 40; k++) begin
            power = power / mm;
            if (k % 2 == 1)
                sum = sum - power / 128'(2 * k + 1);
            else
                sum = sum + power / 128'(2 * k + 1);
        end
        return sum;
    endfunction

    function automatic logic [ROM_W-1:0] quarterSine(input int unsigned idx);
        logic [127:0] halfPi;
        logic [127:0] x;
        logic [127:0] x2;
        logic [127:0] term;
        logic [127:0] sum;
        logic [127:0] scaled;
        halfPi = 128'd8 * atanInv(5) - 128'd2 * atanInv(239);
        x      = (halfPi * 128'(idx)) >> 10;
        x2     = (x * x) >> FRAC;
        term   = x;
        sum    = x;
        for (int n = 1; n < 16; n++) begin
            term = ((term * x2) >> FRAC) / 128'((2 * n) * (2 * n + 1));
            if (n % 2 == 1)
                sum = sum - term;
            else
                sum = sum + term;
        end
        scaled = sum * 128'(AMP) + (128'd1 << (FRAC - 1));
        return ROM_W'(scaled >> FRAC);
    endfunction

endpackage

// File: rtl/nco_sin_rom.sv
// Quarter-wave sine table, 1025 x 12 bits, with one registered read port.
module nco_sin_rom
    import nco_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [ROM_AW-1:0] addr_i,
    output logic [ROM_W-1:0]  data_o
);

    logic [ROM_W-1:0] romTable [ROM_DEPTH];
    logic [ROM_W-1:0] data_q;

    // Contents are folded to constants at elaboration; no init file needed
    for (genvar i = 0; i < ROM_DEPTH; i++) begin : gTable
        localparam logic [ROM_W-1:0] VALUE = quarterSine(i);
        assign romTable[i] = VALUE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            data_q <= '0;
        else if (en_i)
            data_q <= romTable[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/nco_1mhz.sv
// Phase-accumulator NCO: 32-bit accumulator, 12-bit phase truncation,
// quarter-wave lookup with quadrant folding, 3-stage pipeline to a 13-bit sine.
module nco_1mhz
    import nco_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clken,
    input  logic [ACC_W-1:0]        phi_inc_i,
    output logic signed [OUT_W-1:0] fsin_o,
    output logic                    out_valid
);

    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        acc_d;
    logic [PHASE_W-1:0]      phase_q;
    logic                    sign_q;
    logic signed [OUT_W-1:0] fsin_q;
    logic signed [OUT_W-1:0] fsin_d;
    logic [2:0]              valid_q;
    logic [OFS_W-1:0]        offset;
    logic [ROM_AW-1:0]       romAddr;
    logic [ROM_W-1:0]        romData;

    always_comb begin
        acc_d  = acc_q + phi_inc_i;
        offset = phase_q[OFS_W-1:0];
        // Odd quadrants read the quarter table backwards, so 1024 is reachable
        if (phase_q[PHASE_W-2])
            romAddr = ROM_AW'(ROM_DEPTH - 1) - {1'b0, offset};
        else
            romAddr = {1'b0, offset};
        if (sign_q)
            fsin_d = -$signed({1'b0, romData});
        else
            fsin_d = $signed({1'b0, romData});
    end

    nco_sin_rom u_rom (
        .clk    (clk),
        .reset_n(reset_n),
        .en_i   (clken),
        .addr_i (romAddr),
        .data_o (romData)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q   <= '0;
            phase_q <= '0;
            sign_q  <= 1'b0;
            fsin_q  <= '0;
            valid_q <= '0;
        end else if (clken) begin
            acc_q   <= acc_d;
            phase_q <= acc_q[ACC_W-1 -: PHASE_W];
            sign_q  <= phase_q[PHASE_W-1];
            fsin_q  <= fsin_d;
            valid_q <= {valid_q[1:0], 1'b1};
        end
    end

    assign fsin_o    = fsin_q;
    assign out_valid = valid_q[2];

endmodule

// File: tb/tb_nco_1mhz.sv
// Randomized self-checking bench for nco_1mhz against a queue-based model
// that evaluates the rounded-sine quadrant formula with real arithmetic.
module tb_nco_1mhz;

    localparam real HALF_PI = 1.5707963267948966;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                clken;
    logic [31:0]         phi_inc_i;
    logic signed [12:0]  fsin_o;
    logic                out_valid;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mAcc = '0;
    int          mFsin = 0;
    int          mValid = 0;
    int          pending[$];
    int          captured[$];

    nco_1mhz dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clken    (clken),
        .phi_inc_i(phi_inc_i),
        .fsin_o   (fsin_o),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    function automatic int goldSample(input logic [31:0] acc);
        int p;
        int quad;
        int ofs;
        int idx;
        int mag;
        p    = int'(acc >> 20);
        quad = p / 1024;
        ofs  = p % 1024;
        idx  = (quad % 2 == 1) ? 1024 - ofs : ofs;
        mag  = $rtoi(4095.0 * $sin(HALF_PI * real'(idx) / 1024.0) + 0.5);
        return (quad >= 2) ? -mag : mag;
    endfunction

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock edge: model each sample as born at its edge and emerging 3 enabled edges later
    task automatic applyStimulus(input logic rstn, input logic en, input logic [31:0] inc);
        reset_n   = rstn;
        clken     = en;
        phi_inc_i = inc;
        @(posedge clk);
        if (!rstn) begin
            mAcc   = '0;
            mFsin  = 0;
            mValid = 0;
            pending.delete();
        end else if (en) begin
            pending.push_back(goldSample(mAcc));
            mAcc = mAcc + inc;
            if (pending.size() == 3) begin
                mFsin  = pending.pop_front();
                mValid = 1;
            end
        end
        #1;
        checkOutput("fsin", int'(fsin_o), mFsin);
        checkOutput("valid", int'(out_valid), mValid);
        if (rstn && en && mValid == 1)
            captured.push_back(int'(fsin_o));
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b1, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0);
        captured.delete();
    endtask

    task automatic releaseAndCount(input logic [31:0] inc, input string tag);
        int edges;
        edges = 0;
        do begin
            applyStimulus(1'b1, 1'b1, inc);
            edges++;
        end while (out_valid !== 1'b1 && edges < 10);
        checkOutput(tag, edges, 3);
    endtask

    initial begin
        int quarter[$];
        int eighth[$];
        int switched[$];
        int minV;
        int maxV;
        int nonZero;
        logic [31:0] inc;

        quarter  = '{0, 4095, 0, -4095};
        eighth   = '{0, 2896, 4095, 2896, 0, -2896, -4095, -2896};
        switched = '{0, 4095, 0, -2896, -4095, -2896, 0};

        resetDut();
        checkOutput("resetFsin", int'(fsin_o), 0);
        checkOutput("resetValid", int'(out_valid), 0);

        releaseAndCount(32'h4000_0000, "latencyQuarter");
        repeat (7) applyStimulus(1'b1, 1'b1, 32'h4000_0000);
        for (int i = 0; i < 8 && i < captured.size(); i++)
            checkOutput("quarterSeq", captured[i], quarter[i % 4]);
        checkOutput("quarterCount", captured.size(), 8);

        resetDut();
        repeat (18) applyStimulus(1'b1, 1'b1, 32'h2000_0000);
        for (int i = 0; i < captured.size(); i++)
            checkOutput("eighthSeq", captured[i], eighth[i % 8]);

        resetDut();
        repeat (1010) applyStimulus(1'b1, 1'b1, 32'h0041_8937);
        minV = 0;
        maxV = 0;
        foreach (captured[i]) begin
            if (captured[i] < minV) minV = captured[i];
            if (captured[i] > maxV) maxV = captured[i];
        end
        checkOutput("slowFirst", captured[0], 0);
        checkOutput("slowSecond", captured[1], 25);
        checkOutput("slowMin", minV, -4095);
        checkOutput("slowMaxInRange", int'(maxV <= 4095), 1);

        resetDut();
        repeat (20) applyStimulus(1'b1, 1'b1, 32'h0);
        nonZero = 0;
        foreach (captured[i]) if (captured[i] != 0) nonZero++;
        checkOutput("zeroIncNonZero", nonZero, 0);
        checkOutput("zeroIncValid", int'(out_valid), 1);

        resetDut();
        for (int i = 0; i < 100; i++)
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 32'h2000_0000);
        for (int i = 0; i < captured.size(); i++)
            checkOutput("clkenSeq", captured[i], eighth[i % 8]);

        repeat (5) applyStimulus(1'b1, 1'b1, 32'h2000_0000);
        applyStimulus(1'b0, 1'b0, 32'h2000_0000);
        checkOutput("midResetFsin", int'(fsin_o), 0);
        checkOutput("midResetValid", int'(out_valid), 0);
        captured.delete();
        releaseAndCount(32'h2000_0000, "latencyRestart");
        applyStimulus(1'b1, 1'b1, 32'h2000_0000);
        checkOutput("restartFirst", captured[0], 0);
        checkOutput("restartSecond", captured[1], 2896);

        resetDut();
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 1'b1, (i < 2) ? 32'h4000_0000 : 32'h2000_0000);
        for (int i = 0; i < switched.size() && i < captured.size(); i++)
            checkOutput("incSwitch", captured[i], switched[i]);
        checkOutput("incSwitchCount", captured.size(), 7);

        resetDut();
        inc = $urandom;
        for (int i = 0; i < 600; i++) begin
            if (i % 40 == 0) inc = $urandom;
            applyStimulus(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) != 0), inc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
